line_fill_sequencer: RTL and testbench
======================================

Name: line_fill_sequencer

Overview:
- Sits between the direct-mapped cache controller and the four-bank main memory.
- On a controller request, it writes a dirty 4-word line back to memory, fills a 4-word line from memory into the cache data array, or does both (write-back first).
- It handles word sequencing, bank-busy back-pressure and read-latency alignment, so the controller sees a single start/done handshake.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- RD_LAT, 2, memory cycles from read issue to valid mem_data_out.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_wb  in  1  one-cycle pulse: write back line at wb_addr
- start_fill  in  1  one-cycle pulse: fill line at fill_addr
- wb_addr  in  ADDR_W  victim line address (bits [2:0] ignored)
- fill_addr  in  ADDR_W  miss address (bits [2:1] = requested word)
- cache_data_out  in  DATA_W  cache word at cache_offset (combinational read)
- mem_data_out  in  DATA_W  memory read data
- mem_busy  in  4  per-bank busy
- mem_stall  in  1  global memory stall
- mem_err  in  1  memory error
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- cache_offset  out  3  cache word offset (bit 0 always 0)
- cache_data_in  out  DATA_W  fill data to cache
- cache_we  out  1  cache data write enable
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error for current operation

Behaviour:
- Reset: all outputs 0; state IDLE; counters and latency pipe cleared. Reset mid-operation aborts at once; no further strobes.
- Bank of a word = mem_addr[2:1]. A word issues only when !mem_stall && !mem_busy[bank]. Otherwise the word index holds and the strobe stays low that cycle.
- IDLE:
  - start_wb → WB; start_wb && start_fill → WB, then FILL; start_fill alone → FILL.
  - Latch both addresses; clear err.
  - Starts while busy=1 are ignored.
- WB:
  - Word i (0..3): cache_offset={i,0}, mem_addr={wb_addr[15:3],i,0}, mem_data_in=cache_data_out, mem_wr=1 on issue.
  - After word 3 issues: go to FILL if pending, else DONE.
- FILL issue:
  - Word order 0,1,2,3. mem_rd=1, mem_addr={fill_addr[15:3],i,0}.
  - Push {valid,i} into an RD_LAT-deep pipe; a stalled cycle pushes valid=0.
- FILL return:
  - When the pipe head is valid: cache_we=1, cache_offset={head_i,0}, cache_data_in=mem_data_out.
  - Return writes may coincide with later issues; both happen in the same cycle.
- DRAIN: entered after word 3 issues; waits until the pipe is empty, then DONE.
- DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- busy=1 in every state except IDLE.
- Fill-only minimum latency, start to done: 4 issue + RD_LAT drain + 1 = 7 cycles. WB-only: 5. Combined: 11.
- mem_err sampled while busy sets err (sticky until next start). The operation still completes all words.
- mem_rd and mem_wr are never high in the same cycle.

Optional Feature:
- CRITICAL_WORD_FIRST_EN:
  - Defined: fill order starts at fill_addr[2:1] and wraps mod 4 (e.g. 2,3,0,1). Add output crit_valid (1 bit), pulsing with cache_we of the first returned word, so the controller can forward early. Write-back order is unchanged.
  - Undefined: order always 0..3; no crit_valid port.

Decomposition:
- Shared package: state enum (IDLE, WB, FILL, DRAIN, DONE), WORDS_PER_LINE=4, OFFSET_LSB=1, OFFSET_W=2.
- One natural sub-module: rd_latency_pipe, an RD_LAT-deep shift register of {valid, word_idx} with synchronous clear.

Test Plan:
- Fill-only, fill_addr=0x1234, no busy → mem_rd at 0x1230, 0x1232, 0x1234, 0x1236 on cycles 1-4; cache_we offsets 0, 2, 4, 6 on cycles 3-6; done on cycle 7.
- WB-only, wb_addr=0x00A0, cache words 0x1111..0x4444 → mem_wr at 0x00A0..0x00A6 with matching data; done on cycle 5; no cache_we.
- Combined, wb 0x0040 / fill 0x0080 → all four writes precede the first read; done on cycle 11; mem_rd and mem_wr never both high.
- mem_busy[1]=1 for 3 cycles during fill → word 1 issue delayed 3 cycles; pipe bubbles carry valid=0; all 4 cache writes occur with correct data; done delayed 3 cycles.
- mem_err pulse during WB → err=1 through done, cleared on next start. Reset asserted mid-FILL → next cycle all outputs 0, no further cache_we.
- With CRITICAL_WORD_FIRST_EN, fill_addr=0x0106 → reads at 0x0106, 0x0100, 0x0102, 0x0104; crit_valid together with the offset-6 cache_we.

Source files
------------

// File: rtl/line_fill_sequencer_pkg.sv
// Shared types and constants for the cache line fill / write-back sequencer.
package line_fill_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_LSB     = 1;
    localparam int OFFSET_W       = 2;

    // Word index to cache byte offset; bit 0 is always zero for 16-bit words.
    function automatic logic [OFFSET_W:0] word_offset(input logic [OFFSET_W-1:0] idx);
        return {idx, 1'b0};
    endfunction

endpackage

// File: rtl/line_fill_sequencer_rd_latency_pipe.sv
// Shift register tracking outstanding memory reads: each stage holds {valid, word index}.
module rd_latency_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push_valid,
    input  logic [IDX_W-1:0] push_idx,
    output logic             head_valid,
    output logic [IDX_W-1:0] head_idx,
    output logic             inflight
);

    logic [DEPTH-1:0] valid_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            idx_q[0]   <= push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign head_valid = valid_q[DEPTH-1];
    assign head_idx   = idx_q[DEPTH-1];

    // Reads still in flight behind the head; the head itself retires this cycle.
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            inflight = inflight | valid_q[i];
        end
    end

endmodule

// File: rtl/line_fill_sequencer.sv
// Cache line write-back / fill sequencer between cache controller and banked memory.
// Optional critical-word-first fill order: define CRITICAL_WORD_FIRST_EN.
module line_fill_sequencer
    import line_fill_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wb,
    input  logic              start_fill,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] cache_data_out,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [3:0]        mem_busy,
    input  logic              mem_stall,
    input  logic              mem_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [2:0]        cache_offset,
    output logic [DATA_W-1:0] cache_data_in,
    output logic              cache_we,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic              crit_valid,
`endif
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state;
    logic [OFFSET_W-1:0] word_cnt;
    logic [OFFSET_W-1:0] fill_base;
    logic [OFFSET_W-1:0] fill_word;
    logic [OFFSET_W-1:0] cur_word;
    logic [ADDR_W-1:3]   wb_line;
    logic [ADDR_W-1:3]   fill_line;
    logic                fill_pending;
    logic                issuing;
    logic                head_valid;
    logic [OFFSET_W-1:0] head_idx;
    logic                inflight;
    logic                start_any;
    logic                unused_bits;

    assign unused_bits = ^{wb_addr[2:0], fill_addr[2:0]};
    assign start_any   = start_wb | start_fill;

    assign fill_word = fill_base + word_cnt;
    assign cur_word  = (state == FILL) ? fill_word : word_cnt;
    // A word may only go out when its bank is free and memory is not globally stalled.
    assign issuing   = ((state == WB) || (state == FILL)) && !mem_stall && !mem_busy[cur_word];

    rd_latency_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (OFFSET_W)
    ) u_pipe (
        .clk        (clk),
        .clr        (rst),
        .push_valid (issuing && (state == FILL)),
        .push_idx   (fill_word),
        .head_valid (head_valid),
        .head_idx   (head_idx),
        .inflight   (inflight)
    );

    always_comb begin
        mem_addr      = '0;
        mem_data_in   = '0;
        mem_wr        = 1'b0;
        mem_rd        = 1'b0;
        cache_offset  = '0;
        cache_data_in = '0;
        cache_we      = 1'b0;
        if (state == WB) begin
            mem_addr     = {wb_line, word_cnt, 1'b0};
            mem_data_in  = cache_data_out;
            mem_wr       = issuing;
            cache_offset = word_offset(word_cnt);
        end else if (state == FILL) begin
            mem_addr = {fill_line, fill_word, 1'b0};
            mem_rd   = issuing;
        end
        // Returning read data owns the cache port; it never overlaps write-back.
        if (head_valid) begin
            cache_we      = 1'b1;
            cache_offset  = word_offset(head_idx);
            cache_data_in = mem_data_out;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef CRITICAL_WORD_FIRST_EN
    logic crit_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            crit_pending <= 1'b0;
        end else if (state == IDLE && start_any) begin
            crit_pending <= 1'b1;
        end else if (head_valid) begin
            crit_pending <= 1'b0;
        end
    end

    assign crit_valid = head_valid && crit_pending;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word_cnt     <= '0;
            fill_base    <= '0;
            wb_line      <= '0;
            fill_line    <= '0;
            fill_pending <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (state != IDLE && mem_err) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_any) begin
                        wb_line      <= wb_addr[ADDR_W-1:3];
                        fill_line    <= fill_addr[ADDR_W-1:3];
`ifdef CRITICAL_WORD_FIRST_EN
                        fill_base    <= fill_addr[2:1];
`else
                        fill_base    <= '0;
`endif
                        fill_pending <= start_wb && start_fill;
                        word_cnt     <= '0;
                        err          <= 1'b0;
                        state        <= start_wb ? WB : FILL;
                    end
                end
                WB: begin
                    if (issuing) begin
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'(WORDS_PER_LINE - 1)) begin
                            fill_pending <= 1'b0;
                            state        <= fill_pending ? FILL : DONE;
                        end
                    end
                end
                FILL: begin
                    if (issuing) begin
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'(WORDS_PER_LINE - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_sequencer.sv
// Directed self-checking bench for line_fill_sequencer (honours CRITICAL_WORD_FIRST_EN).
module tb_line_fill_sequencer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_wb;
    logic              start_fill;
    logic [ADDR_W-1:0] wb_addr;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] cache_data_out;
    logic [DATA_W-1:0] mem_data_out;
    logic [3:0]        mem_busy;
    logic              mem_stall;
    logic              mem_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wr;
    logic              mem_rd;
    logic [2:0]        cache_offset;
    logic [DATA_W-1:0] cache_data_in;
    logic              cache_we;
    logic              busy;
    logic              done;
    logic              err;
`ifdef CRITICAL_WORD_FIRST_EN
    logic              crit_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] cache_words [4];
    logic [DATA_W-1:0] rd_data_q [RD_LAT];

    always #5 clk = ~clk;

    line_fill_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_wb       (start_wb),
        .start_fill     (start_fill),
        .wb_addr        (wb_addr),
        .fill_addr      (fill_addr),
        .cache_data_out (cache_data_out),
        .mem_data_out   (mem_data_out),
        .mem_busy       (mem_busy),
        .mem_stall      (mem_stall),
        .mem_err        (mem_err),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_wr         (mem_wr),
        .mem_rd         (mem_rd),
        .cache_offset   (cache_offset),
        .cache_data_in  (cache_data_in),
        .cache_we       (cache_we),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_valid     (crit_valid),
`endif
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Cache array read port and a memory whose read data is address ^ 0xA5A5 after RD_LAT cycles.
    assign cache_data_out = cache_words[cache_offset[2:1]];
    assign mem_data_out   = rd_data_q[RD_LAT-1];

    always @(posedge clk) begin
        rd_data_q[0] <= mem_rd ? (mem_addr ^ 16'hA5A5) : 16'h0000;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_data_q[i] <= rd_data_q[i-1];
        end
    end

    function automatic logic [1:0] fill_base_of(input logic [15:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
        return a[2:1];
`else
        return 2'd0;
`endif
    endfunction

    // Pulse a start for one cycle; returns at the start of cycle 1 (just after the edge).
    task automatic start_op(input logic wb, input logic fill, input logic [15:0] wa, input logic [15:0] fa);
        start_wb   = wb;
        start_fill = fill;
        wb_addr    = wa;
        fill_addr  = fa;
        @(posedge clk); #1;
        start_wb   = 1'b0;
        start_fill = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] got;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        got = {busy, done, err, mem_rd, mem_wr, cache_we, mem_addr, cache_offset, 2'b00};
        n_checks++;
        if (got !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fill_only();
        logic [15:0] fa;
        logic [1:0]  base;
        logic [1:0]  w;
        logic [15:0] exp_addr;
        logic        exp_rd, exp_we;
        fa   = 16'h1234;
        base = fill_base_of(fa);
        start_op(1'b0, 1'b1, 16'h0000, fa);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            exp_rd = (cyc >= 1 && cyc <= 4);
            exp_we = (cyc >= 3 && cyc <= 6);
            n_checks++;
            if (mem_rd !== exp_rd || mem_wr !== 1'b0) begin
                n_errors++;
                $display("FAIL fill_strobes cyc=%0d rd=%b wr=%b exp_rd=%b exp_wr=0", cyc, mem_rd, mem_wr, exp_rd);
            end
            if (exp_rd) begin
                w = base + 2'(cyc - 1);
                exp_addr = {fa[15:3], w, 1'b0};
                n_checks++;
                if (mem_addr !== exp_addr) begin
                    n_errors++;
                    $display("FAIL fill_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_addr);
                end
            end
            n_checks++;
            if (cache_we !== exp_we) begin
                n_errors++;
                $display("FAIL fill_we cyc=%0d got=%b exp=%b", cyc, cache_we, exp_we);
            end
            if (exp_we) begin
                w = base + 2'(cyc - 3);
                exp_addr = {fa[15:3], w, 1'b0};
                n_checks++;
                if (cache_offset !== {w, 1'b0} || cache_data_in !== (exp_addr ^ 16'hA5A5)) begin
                    n_errors++;
                    $display("FAIL fill_ret cyc=%0d off=%0d data=%h exp_off=%0d exp_data=%h",
                             cyc, cache_offset, cache_data_in, {w, 1'b0}, exp_addr ^ 16'hA5A5);
                end
            end
`ifdef CRITICAL_WORD_FIRST_EN
            n_checks++;
            if (crit_valid !== (cyc == 3)) begin
                n_errors++;
                $display("FAIL fill_crit cyc=%0d got=%b exp=%b", cyc, crit_valid, (cyc == 3));
            end
`endif
            n_checks++;
            if (done !== (cyc == 7) || busy !== (cyc <= 7)) begin
                n_errors++;
                $display("FAIL fill_done cyc=%0d done=%b busy=%b exp_done=%b exp_busy=%b",
                         cyc, done, busy, (cyc == 7), (cyc <= 7));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wb_only();
        logic [15:0] exp_addr;
        logic        exp_wr;
        start_op(1'b1, 1'b0, 16'h00A0, 16'h0000);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            exp_wr = (cyc >= 1 && cyc <= 4);
            n_checks++;
            if (mem_wr !== exp_wr || mem_rd !== 1'b0 || cache_we !== 1'b0) begin
                n_errors++;
                $display("FAIL wb_strobes cyc=%0d wr=%b rd=%b we=%b exp_wr=%b", cyc, mem_wr, mem_rd, cache_we, exp_wr);
            end
            if (exp_wr) begin
                exp_addr = 16'h00A0 + 16'(2 * (cyc - 1));
                n_checks++;
                if (mem_addr !== exp_addr || mem_data_in !== cache_words[cyc-1]) begin
                    n_errors++;
                    $display("FAIL wb_word cyc=%0d addr=%h data=%h exp_addr=%h exp_data=%h",
                             cyc, mem_addr, mem_data_in, exp_addr, cache_words[cyc-1]);
                end
            end
            n_checks++;
            if (done !== (cyc == 5) || busy !== (cyc <= 5)) begin
                n_errors++;
                $display("FAIL wb_done cyc=%0d done=%b busy=%b", cyc, done, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_combined();
        logic [15:0] fa;
        logic [1:0]  base;
        logic [1:0]  w;
        logic [15:0] exp_addr;
        logic        exp_wr, exp_rd, exp_we;
        fa   = 16'h0080;
        base = fill_base_of(fa);
        start_op(1'b1, 1'b1, 16'h0040, fa);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            exp_wr = (cyc >= 1 && cyc <= 4);
            exp_rd = (cyc >= 5 && cyc <= 8);
            exp_we = (cyc >= 7 && cyc <= 10);
            n_checks++;
            if (mem_wr !== exp_wr || mem_rd !== exp_rd || cache_we !== exp_we) begin
                n_errors++;
                $display("FAIL comb_strobes cyc=%0d wr=%b rd=%b we=%b exp=%b%b%b",
                         cyc, mem_wr, mem_rd, cache_we, exp_wr, exp_rd, exp_we);
            end
            n_checks++;
            if (mem_wr === 1'b1 && mem_rd === 1'b1) begin
                n_errors++;
                $display("FAIL comb_rd_wr_overlap cyc=%0d rd=1 wr=1 exp=never both", cyc);
            end
            if (exp_wr || exp_rd) begin
                w = base + 2'(cyc - 5);
                exp_addr = exp_wr ? (16'h0040 + 16'(2 * (cyc - 1))) : {fa[15:3], w, 1'b0};
                n_checks++;
                if (mem_addr !== exp_addr) begin
                    n_errors++;
                    $display("FAIL comb_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_addr);
                end
            end
            n_checks++;
            if (done !== (cyc == 11)) begin
                n_errors++;
                $display("FAIL comb_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 11));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bank_busy();
        logic [15:0] exp_addr;
        logic        exp_rd, exp_we;
        int          k;
        start_op(1'b0, 1'b1, 16'h0000, 16'h2220);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            mem_busy = (cyc >= 2 && cyc <= 4) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            exp_rd = (cyc == 1) || (cyc >= 5 && cyc <= 7);
            exp_we = (cyc == 3) || (cyc >= 7 && cyc <= 9);
            n_checks++;
            if (mem_rd !== exp_rd || cache_we !== exp_we) begin
                n_errors++;
                $display("FAIL busy_strobes cyc=%0d rd=%b we=%b exp_rd=%b exp_we=%b", cyc, mem_rd, cache_we, exp_rd, exp_we);
            end
            if (exp_rd) begin
                k = (cyc == 1) ? 0 : cyc - 4;
                exp_addr = 16'h2220 + 16'(2 * k);
                n_checks++;
                if (mem_addr !== exp_addr) begin
                    n_errors++;
                    $display("FAIL busy_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_addr);
                end
            end
            if (exp_we) begin
                k = (cyc == 3) ? 0 : cyc - 6;
                exp_addr = 16'h2220 + 16'(2 * k);
                n_checks++;
                if (cache_offset !== 3'(2 * k) || cache_data_in !== (exp_addr ^ 16'hA5A5)) begin
                    n_errors++;
                    $display("FAIL busy_ret cyc=%0d off=%0d data=%h exp_off=%0d exp_data=%h",
                             cyc, cache_offset, cache_data_in, 2 * k, exp_addr ^ 16'hA5A5);
                end
            end
            n_checks++;
            if (done !== (cyc == 10)) begin
                n_errors++;
                $display("FAIL busy_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 10));
            end
            @(posedge clk); #1;
        end
        mem_busy = 4'b0000;
    endtask

    task automatic test_err();
        int cyc;
        start_op(1'b1, 1'b0, 16'h00A0, 16'h0000);
        for (cyc = 1; cyc <= 6; cyc++) begin
            mem_err = (cyc == 2);
            @(negedge clk);
            n_checks++;
            if (err !== (cyc >= 3) || done !== (cyc == 5)) begin
                n_errors++;
                $display("FAIL err_sticky cyc=%0d err=%b done=%b exp_err=%b exp_done=%b",
                         cyc, err, done, (cyc >= 3), (cyc == 5));
            end
            @(posedge clk); #1;
        end
        mem_err = 1'b0;
        start_op(1'b1, 1'b0, 16'h00A0, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL err_clear got_err=%b busy=%b exp_err=0 exp_busy=1", err, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL err_second_done got=%b exp=1 within 20 cycles", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fill();
        logic [26:0] got;
        start_op(1'b0, 1'b1, 16'h0000, 16'h2220);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            rst = (cyc == 4);
            @(negedge clk);
            if (cyc == 5) begin
                got = {busy, done, err, mem_rd, mem_wr, cache_we, mem_addr, cache_offset, 2'b00};
                n_checks++;
                if (got !== 27'd0) begin
                    n_errors++;
                    $display("FAIL rst_mid_outputs got=%h exp=0", got);
                end
            end
            if (cyc >= 5) begin
                n_checks++;
                if (cache_we !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rst_mid_quiet cyc=%0d we=%b busy=%b rd=%b exp=0", cyc, cache_we, busy, mem_rd);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_ignore_start();
        start_op(1'b0, 1'b1, 16'h0000, 16'h2220);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            start_wb = (cyc == 2);
            wb_addr  = 16'h0400;
            @(negedge clk);
            n_checks++;
            if (mem_wr !== 1'b0 || done !== (cyc == 7)) begin
                n_errors++;
                $display("FAIL ignore_start cyc=%0d wr=%b done=%b exp_wr=0 exp_done=%b", cyc, mem_wr, done, (cyc == 7));
            end
            @(posedge clk); #1;
        end
        start_wb = 1'b0;
    endtask

`ifdef CRITICAL_WORD_FIRST_EN
    task automatic test_cwf();
        logic [15:0] exp_list [4];
        exp_list[0] = 16'h0106;
        exp_list[1] = 16'h0100;
        exp_list[2] = 16'h0102;
        exp_list[3] = 16'h0104;
        start_op(1'b0, 1'b1, 16'h0000, 16'h0106);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc <= 4) begin
                n_checks++;
                if (mem_rd !== 1'b1 || mem_addr !== exp_list[cyc-1]) begin
                    n_errors++;
                    $display("FAIL cwf_addr cyc=%0d rd=%b addr=%h exp=%h", cyc, mem_rd, mem_addr, exp_list[cyc-1]);
                end
            end
            n_checks++;
            if (crit_valid !== (cyc == 3) || (cyc == 3 && cache_offset !== 3'd6)) begin
                n_errors++;
                $display("FAIL cwf_crit cyc=%0d crit=%b off=%0d exp_crit=%b exp_off=6", cyc, crit_valid, cache_offset, (cyc == 3));
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start_wb   = 1'b0;
        start_fill = 1'b0;
        wb_addr    = '0;
        fill_addr  = '0;
        mem_busy   = 4'b0000;
        mem_stall  = 1'b0;
        mem_err    = 1'b0;
        cache_words[0] = 16'h1111;
        cache_words[1] = 16'h2222;
        cache_words[2] = 16'h3333;
        cache_words[3] = 16'h4444;
        @(posedge clk); #1;

        test_reset();
        test_fill_only();
        test_wb_only();
        test_combined();
        test_bank_busy();
        test_err();
        test_reset_mid_fill();
        test_ignore_start();
`ifdef CRITICAL_WORD_FIRST_EN
        test_cwf();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
